// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer reusing one 8-bit Sklansky adder
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_cin/in_sub request side;
//        out_valid/out_ready/out_sum/out_cout/out_ovf result side; busy high outside IDLE.

module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] gp, pp, gn, pn;
    logic [8:0] c;
    logic [2:0] j;
    // Sklansky tree: at level k, every bit with bit k of its index set merges with
    // the top bit of the preceding 2^k-aligned block.
    always_comb begin
        gp = a & b;
        pp = a ^ b;
        gn = '0;
        pn = '0;
        j  = '0;
        for (int k = 0; k < 3; k++) begin
            gn = gp;
            pn = pp;
            for (int i = 0; i < 8; i++) begin
                if (((i >> k) & 1) == 1) begin
                    j     = 3'(((i >> k) << k) - 1);
                    gn[i] = gp[i] | (pp[i] & gp[j]);
                    pn[i] = pp[i] & pp[j];
                end
            end
            gp = gn;
            pp = pn;
        end
        c[0] = cin;
        for (int i = 0; i < 8; i++) c[i+1] = gp[i] | (pp[i] & cin);
    end
    assign sum  = (a ^ b) ^ c[7:0];
    assign cout = c[8];
endmodule

module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WORDS-1:0] in_a,
    input  logic [8*WORDS-1:0] in_b,
    input  logic               in_cin,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_ovf,
    output logic               busy
);
    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic            cout_q, cout_d, ovf_q, ovf_d, valid_q, valid_d;
    logic [7:0]      a_byte, b_byte, s_byte;
    logic            s_cout, last;

    assign a_byte = opa_q[8*idx_q +: 8];
    assign b_byte = opb_q[8*idx_q +: 8];
    assign last   = idx_q == IW'(WORDS - 1);

    adder u_adder (.a(a_byte), .b(b_byte), .cin(carry_q), .sum(s_byte), .cout(s_cout));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        // out_valid trails entry into DONE by one edge and drops on the accepting edge
        valid_d = (state_q == DONE) && !(valid_q && out_ready);
        case (state_q)
            IDLE: if (in_valid) begin
                opa_d   = in_a;
                opb_d   = in_sub ? ~in_b : in_b;
                carry_d = in_cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d[8*idx_q +: 8] = s_byte;
                carry_d = s_cout;
                if (last) begin
                    cout_d  = s_cout;
                    ovf_d   = (a_byte[7] == b_byte[7]) && (s_byte[7] != a_byte[7]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: state_d = (valid_q && out_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = valid_q;
    assign out_sum   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule
